// File: rtl/layer_controller_if.sv
// Handshake and data bundle between the layer controller and the block that
// sequences it. The slave side is the controller; the master side drives start.
interface layer_controller_if #(
    parameter int dataWidth = 16,
    parameter int numInputs = 16
);
    logic                           start;
    logic [dataWidth*numInputs-1:0] vectorIn;
    logic                           neuronValid;
    logic [dataWidth*numInputs-1:0] layerIn;
    logic                           serReset;
    logic                           serEnable;
    logic                           busy;
    logic                           done;
    logic                           timeoutErr;

    modport master (
        output start, vectorIn, neuronValid,
        input  layerIn, serReset, serEnable, busy, done, timeoutErr
    );

    modport slave (
        input  start, vectorIn, neuronValid,
        output layerIn, serReset, serEnable, busy, done, timeoutErr
    );
endinterface

// File: rtl/layer_controller.sv
// Sequences one neural-network layer: latch the input vector, clear and then
// stream the serializer, wait (bounded) for the neurons, and pulse done.
module layer_controller #(
    parameter int numInputs     = 16,
    parameter int dataWidth     = 16,
    parameter int timeoutCycles = 64,
    parameter int cntWidth      = $clog2(numInputs + timeoutCycles + 2)
) (
    input  logic               clk,
    input  logic               reset,
    layer_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        WAIT,
        DONE
    } state_t;

    localparam logic [cntWidth-1:0] RUN_LAST  = cntWidth'(numInputs);
    localparam logic [cntWidth-1:0] WAIT_LAST = cntWidth'(timeoutCycles - 1);

    state_t              state;
    logic [cntWidth-1:0] cnt;

    // NOTE: every register here, state and outputs alike, is written with <= so
    // that all of them see the pre-edge values of each other within one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.layerIn    <= '0;
            bus.serReset   <= 1'b0;
            bus.serEnable  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.timeoutErr <= 1'b0;
        end else begin
            bus.serReset <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.layerIn    <= bus.vectorIn;
                        bus.timeoutErr <= 1'b0;
                        bus.serReset   <= 1'b1;
                        bus.busy       <= 1'b1;
                        state          <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt           <= '0;
                    bus.serEnable <= 1'b1;
                    state         <= RUN;
                end
                // One alignment cycle plus numInputs beats: counts 0..numInputs.
                RUN: begin
                    if (cnt == RUN_LAST) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // neuronValid is checked first so it wins a tie with the timeout.
                WAIT: begin
                    if (bus.neuronValid) begin
                        bus.serEnable <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end else if (cnt == WAIT_LAST) begin
                        bus.timeoutErr <= 1'b1;
                        bus.serEnable  <= 1'b0;
                        bus.done       <= 1'b1;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    cnt      <= '0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_controller.sv
// Directed bench for layer_controller: normal run, timeout, tie, held start,
// neuronValid outside WAIT, and reset in the middle of RUN.
module tb_layer_controller;

    localparam int NI = 16;
    localparam int DW = 16;
    localparam int TO = 64;
    localparam int VW = NI * DW;

    localparam logic [VW-1:0] PAT_A = {8{32'h1234_ABCD}};
    localparam logic [VW-1:0] PAT_B = {16{16'hA5C3}};
    localparam logic [VW-1:0] PAT_C = {4{64'hDEAD_BEEF_0F1E_2D3C}};
    localparam logic [VW-1:0] PAT_D = {2{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF}};

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    layer_controller_if #(.dataWidth(DW), .numInputs(NI)) bus ();

    layer_controller #(
        .numInputs    (NI),
        .dataWidth    (DW),
        .timeoutCycles(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one run and observe it cycle by cycle; cycle 1 is the CLEAR cycle.
    // neuronValid is driven high for the cycles numbered nv_a and nv_b.
    task automatic run(input logic [VW-1:0] vec, input int nv_a, input int nv_b,
                       input bit hold, input logic [VW-1:0] vec_next,
                       output int sr_n, output int en_n, output int done_at,
                       output int ovl, output logic err);
        sr_n = 0; en_n = 0; done_at = 0; ovl = 0; err = 1'b0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.vectorIn = vec;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start    = hold;
                bus.vectorIn = vec_next;
            end
            sr_n += int'(bus.serReset);
            en_n += int'(bus.serEnable);
            if (bus.serReset && bus.serEnable) ovl++;
            if (bus.done) begin
                done_at = c;
                err     = bus.timeoutErr;
                break;
            end
            bus.neuronValid = (c == nv_a) || (c == nv_b);
        end
        bus.neuronValid = 1'b0;
    endtask

    // Counts negedges until done is seen; -1 if the budget runs out.
    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (bus.done) begin
                n = c;
                break;
            end
        end
    endtask

    int   sr_n, en_n, done_at, ovl, n, done_seen;
    logic err;

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.neuronValid = 1'b0;
        bus.vectorIn    = PAT_D;
        repeat (3) @(negedge clk);
        check("rst_busy",    bus.busy,       1'b0);
        check("rst_done",    bus.done,       1'b0);
        check("rst_en",      bus.serEnable,  1'b0);
        check("rst_sr",      bus.serReset,   1'b0);
        check("rst_err",     bus.timeoutErr, 1'b0);
        check("rst_layerIn", bus.layerIn,    '0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", bus.busy, 1'b0);

        // Normal run: neuronValid in the third WAIT cycle (cycle 21).
        run(PAT_A, 21, 0, 1'b0, PAT_B, sr_n, en_n, done_at, ovl, err);
        check("norm_sr_cycles", 32'(sr_n),    32'd1);
        check("norm_en_cycles", 32'(en_n),    32'd20);
        check("norm_done_at",   32'(done_at), 32'd22);
        check("norm_overlap",   32'(ovl),     32'd0);
        check("norm_err",       err,          1'b0);
        check("norm_layerIn",   bus.layerIn,  PAT_A);
        @(negedge clk);
        check("norm_done_once", bus.done, 1'b0);
        check("norm_idle",      bus.busy, 1'b0);

        // neuronValid pulsed during RUN must not shorten RUN.
        run(PAT_B, 10, 21, 1'b0, PAT_A, sr_n, en_n, done_at, ovl, err);
        check("runnv_done_at", 32'(done_at), 32'd22);
        check("runnv_en",      32'(en_n),    32'd20);
        check("runnv_layerIn", bus.layerIn,  PAT_B);

        // Timeout: 64 WAIT cycles, done at cycle 1+17+64+1.
        run(PAT_C, 0, 0, 1'b0, PAT_A, sr_n, en_n, done_at, ovl, err);
        check("to_done_at", 32'(done_at), 32'd83);
        check("to_en",      32'(en_n),    32'd81);
        check("to_err",     err,          1'b1);
        check("to_overlap", 32'(ovl),     32'd0);
        @(negedge clk);
        check("to_done_once",  bus.done,       1'b0);
        check("to_err_sticky", bus.timeoutErr, 1'b1);

        // Next start clears timeoutErr; neuronValid held high gives k=1.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.neuronValid = 1'b1;
        check("clr_err",  bus.timeoutErr, 1'b0);
        check("clr_sr",   bus.serReset,   1'b1);
        check("clr_busy", bus.busy,       1'b1);
        wait_done(60, n);
        bus.neuronValid = 1'b0;
        check("kmin_latency", 32'(n), 32'd19);
        @(negedge clk);

        // Tie: neuronValid on the last WAIT cycle (count 63) wins.
        run(PAT_D, 82, 0, 1'b0, PAT_A, sr_n, en_n, done_at, ovl, err);
        check("tie_done_at", 32'(done_at), 32'd83);
        check("tie_err",     err,          1'b0);
        @(negedge clk);

        // start held high: DONE cycle ignores it, IDLE accepts the new vector.
        run(PAT_A, 21, 0, 1'b1, PAT_B, sr_n, en_n, done_at, ovl, err);
        check("hold_done_at",  32'(done_at), 32'd22);
        check("hold_layerIn1", bus.layerIn,  PAT_A);
        @(negedge clk);
        check("hold_idle_busy", bus.busy,    1'b0);
        check("hold_idle_done", bus.done,    1'b0);
        check("hold_idle_lin",  bus.layerIn, PAT_A);
        @(negedge clk);
        check("hold_clear_sr",  bus.serReset, 1'b1);
        check("hold_layerIn2",  bus.layerIn,  PAT_B);
        bus.start       = 1'b0;
        bus.neuronValid = 1'b1;
        wait_done(60, n);
        bus.neuronValid = 1'b0;
        check("hold_run2_latency", 32'(n), 32'd19);
        @(negedge clk);

        // Reset at RUN beat 8 (cycle 10): abort with no done.
        bus.start    = 1'b1;
        bus.vectorIn = PAT_C;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        check("mid_en_before", bus.serEnable, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy",    bus.busy,      1'b0);
        check("mid_en",      bus.serEnable, 1'b0);
        check("mid_done",    bus.done,      1'b0);
        check("mid_layerIn", bus.layerIn,   '0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            done_seen += int'(bus.done);
        end
        check("mid_no_done", 32'(done_seen), 32'd0);
        run(PAT_B, 21, 0, 1'b0, PAT_A, sr_n, en_n, done_at, ovl, err);
        check("post_done_at", 32'(done_at), 32'd22);
        check("post_layerIn", bus.layerIn,  PAT_B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_controller.md
LAYER_CONTROLLER -- requirements
Module: layer_controller

Interface
REQ-001 SHALL have parameter numInputs, default 16, meaning inputs per neuron / serializer beats per run.
REQ-002 SHALL have parameter dataWidth, default 16, meaning bits per input word.
REQ-003 SHALL have parameter timeoutCycles, default 64, meaning maximum WAIT-state cycles before abort.
REQ-004 SHALL have parameter cntWidth, default $clog2(numInputs+timeoutCycles+2), meaning internal cycle-counter width.
REQ-005 SHALL use one clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  run request, sampled only in IDLE.
REQ-007 vectorIn  in  dataWidth*numInputs  layer input vector, captured on accepted start.
REQ-008 neuronValid  in  1  downstream neurons report result ready.
REQ-009 layerIn  out  dataWidth*numInputs  registered copy of vectorIn, drives serializer data input.
REQ-010 serReset  out  1  one-cycle clear to serializer and neurons.
REQ-011 serEnable  out  1  enable to serializer and neurons.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 timeoutErr  out  1  sticky abort flag.

Function
REQ-015 SHALL implement FSM states IDLE, CLEAR, RUN, WAIT, DONE; all outputs registered or decoded from state only.
REQ-016 IDLE: start=1 -> capture vectorIn into layerIn, clear timeoutErr, next CLEAR; start=0 -> stay; layerIn holds its value.
REQ-017 CLEAR: serReset=1 for exactly one cycle, cycle counter cleared, next RUN.
REQ-018 RUN: serEnable=1; counter increments each cycle; after exactly numInputs+1 cycles (1 alignment delay + numInputs beats) -> WAIT, counter cleared.
REQ-019 WAIT: serEnable=1; neuronValid=1 -> DONE; else counter increments; counter reaching timeoutCycles-1 with neuronValid=0 -> set timeoutErr, next DONE.
REQ-020 neuronValid and timeout on the same cycle: neuronValid wins, timeoutErr stays 0.
REQ-021 DONE: done=1, serEnable=0, one cycle, next IDLE unconditionally.
REQ-022 start outside IDLE SHALL be ignored (no queueing); start in DONE cycle not accepted.
REQ-023 neuronValid outside WAIT SHALL be ignored.
REQ-024 latency start-accept to done: 1 (CLEAR) + numInputs+1 (RUN) + k WAIT cycles + 1 (DONE) where k = cycles until neuronValid, minimum k=1.
REQ-025 counter SHALL never wrap; cntWidth sized for max(numInputs+1, timeoutCycles).
REQ-026 serReset and serEnable SHALL never be high in the same cycle.

Reset
REQ-027 reset=1 SHALL force state IDLE, busy=0, done=0, serEnable=0, serReset=0, timeoutErr=0, counter=0, layerIn=0 on the next edge.
REQ-028 reset mid-run (any state) SHALL abort without emitting done; first start after reset release is accepted normally.

Verification
REQ-029 Normal run, numInputs=16: start pulse with vectorIn=pattern, neuronValid raised 3rd WAIT cycle -> serReset 1 cycle, serEnable 17 RUN + 3 WAIT cycles, done at cycle 22 after start, layerIn==pattern.
REQ-030 Timeout: neuronValid held 0 -> WAIT lasts 64 cycles, timeoutErr=1, done pulses once; next start clears timeoutErr.
REQ-031 Tie: neuronValid asserted on final WAIT cycle (63) -> done, timeoutErr=0.
REQ-032 start held high continuously -> back-to-back runs, each start accepted only in IDLE, one done per run, layerIn updated only at IDLE accept.
REQ-033 reset asserted in RUN at beat 8 -> outputs at reset values next cycle, no done pulse, subsequent run completes normally.
REQ-034 neuronValid pulsed during RUN -> ignored, FSM still spends full 17 RUN cycles before WAIT.
